// File: rtl/clock_pkg.sv
// Shared types for the chime/alarm buzzer scheduler.
// Holds the FSM states, buzzer-owner codes and counter widths.
package clock_pkg;

  localparam int BEEP_W  = 4;
  localparam int ALARM_W = 8;

  typedef logic [BEEP_W-1:0]  beep_t;
  typedef logic [ALARM_W-1:0] acnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHIME_ON,
    S_CHIME_OFF,
    S_ALARM_ON,
    S_ALARM_OFF
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'b00,
    SRC_CHIME = 2'b01,
    SRC_ALARM = 2'b10
  } src_t;

endpackage

// File: rtl/bcd_hour_to_beeps.sv
// BCD hour (00-23) to 12-hour beep count (1..12), combinational.
// Ports: hour[7:0] in; count[3:0] beeps, valid = legal BCD hour.
module bcd_hour_to_beeps
  import clock_pkg::*;
(
  input  logic [7:0] hour,
  output logic [3:0] count,
  output logic       valid
);

  logic [7:0] w_bin;

  always_comb begin
    w_bin = 8'(hour[7:4]) * 8'd10 + 8'(hour[3:0]);
    valid = (hour[3:0] <= 4'd9) && (hour <= 8'h23);
    count = 4'd12;
    if (w_bin == 8'd0)
      count = 4'd12;
    else if (w_bin <= 8'd12)
      count = 4'(w_bin);
    else
      count = 4'(w_bin - 8'd12);
  end

endmodule

// File: rtl/chime_scheduler.sv
// Buzzer scheduler: hourly chime (N beeps) and preempting alarm.
// In: clk, rst, tick_en, hour, hour_changed, equal, alarm_stop.
// Out: buzzer, src (01 chime/10 alarm), busy, chime_pending.
module chime_scheduler
  import clock_pkg::*;
#(
  parameter logic [7:0] ALARM_TICKS = 8'd60,
  parameter bit         CHIME_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic [7:0] hour,
  input  logic       hour_changed,
  input  logic       equal,
  input  logic       alarm_stop,
  output logic       buzzer,
  output logic [1:0] src,
  output logic       busy,
  output logic       chime_pending
);

  state_t r_state, w_state_n;
  beep_t  r_beeps, w_beeps_n;
  beep_t  r_pn, w_pn_n;
  acnt_t  r_acnt, w_acnt_n;
  logic   r_pend, w_pend_n;
  logic   r_hc_d, r_eq_d;
  logic   r_buzzer;
  logic [1:0] r_src;
  logic   r_busy;

  logic [3:0] w_cnt;
  logic       w_valid;
  logic       w_chime_req;
  logic       w_alarm_req;

  bcd_hour_to_beeps u_conv (
    .hour  (hour),
    .count (w_cnt),
    .valid (w_valid)
  );

  assign w_chime_req = hour_changed & ~r_hc_d & w_valid & CHIME_EN;
  assign w_alarm_req = equal & ~r_eq_d;

  always_comb begin
    w_state_n = r_state;
    w_beeps_n = r_beeps;
    w_pn_n    = r_pn;
    w_acnt_n  = r_acnt;
    w_pend_n  = r_pend;
    unique case (r_state)
      S_IDLE: begin
        if (w_alarm_req) begin
          w_state_n = S_ALARM_ON;
          w_acnt_n  = ALARM_TICKS;
          if (w_chime_req) begin
            w_pend_n = 1'b1;
            w_pn_n   = w_cnt;
          end
        end else if (w_chime_req) begin
          w_state_n = S_CHIME_ON;
          w_beeps_n = w_cnt;
          w_pend_n  = 1'b0;
        end else if (r_pend) begin
          // deferred chime starts the cycle after the alarm ended
          w_state_n = S_CHIME_ON;
          w_beeps_n = r_pn;
          w_pend_n  = 1'b0;
        end
      end
      S_CHIME_ON, S_CHIME_OFF: begin
        if (w_alarm_req) begin
          // chime is aborted, not resumed
          w_state_n = S_ALARM_ON;
          w_acnt_n  = ALARM_TICKS;
          w_beeps_n = '0;
          if (w_chime_req) begin
            w_pend_n = 1'b1;
            w_pn_n   = w_cnt;
          end
        end else if (tick_en) begin
          if (r_state == S_CHIME_ON) begin
            w_state_n = S_CHIME_OFF;
            w_beeps_n = r_beeps - 4'd1;
          end else if (r_beeps == '0) begin
            w_state_n = S_IDLE;
          end else begin
            w_state_n = S_CHIME_ON;
          end
        end
      end
      S_ALARM_ON, S_ALARM_OFF: begin
        if (w_chime_req) begin
          w_pend_n = 1'b1;
          w_pn_n   = w_cnt;
        end
        if (alarm_stop) begin
          w_state_n = S_IDLE;
          w_acnt_n  = '0;
        end else if (w_alarm_req) begin
          // reload only; phase is kept
          w_acnt_n = ALARM_TICKS;
        end else if (tick_en) begin
          w_acnt_n = r_acnt - 8'd1;
          if (r_acnt <= 8'd1)
            w_state_n = S_IDLE;
          else if (r_state == S_ALARM_ON)
            w_state_n = S_ALARM_OFF;
          else
            w_state_n = S_ALARM_ON;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_beeps  <= '0;
      r_pn     <= '0;
      r_acnt   <= '0;
      r_pend   <= 1'b0;
      r_hc_d   <= 1'b0;
      r_eq_d   <= 1'b0;
      r_buzzer <= 1'b0;
      r_src    <= SRC_NONE;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_beeps  <= w_beeps_n;
      r_pn     <= w_pn_n;
      r_acnt   <= w_acnt_n;
      r_pend   <= w_pend_n;
      r_hc_d   <= hour_changed;
      r_eq_d   <= equal;
      r_buzzer <= (w_state_n == S_CHIME_ON) ||
                  (w_state_n == S_ALARM_ON);
      r_busy   <= (w_state_n != S_IDLE);
      if ((w_state_n == S_CHIME_ON) ||
          (w_state_n == S_CHIME_OFF))
        r_src <= SRC_CHIME;
      else if ((w_state_n == S_ALARM_ON) ||
               (w_state_n == S_ALARM_OFF))
        r_src <= SRC_ALARM;
      else
        r_src <= SRC_NONE;
    end
  end

  assign buzzer        = r_buzzer;
  assign src           = r_src;
  assign busy          = r_busy;
  assign chime_pending = r_pend;

endmodule

// File: tb/tb_chime_scheduler.sv
// Directed bench for chime_scheduler with a pulse-count scoreboard.
// Expected pulse counts are queued at stimulus and popped at completion.
module tb_chime_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_en;
  logic [7:0] hour;
  logic       hour_changed;
  logic       equal;
  logic       alarm_stop;
  logic       buzzer;
  logic [1:0] src;
  logic       busy;
  logic       chime_pending;

  int n_assert = 0;
  int n_fail   = 0;
  int tot_p    = 0;
  int chime_p  = 0;
  logic prev_buz = 1'b0;

  int    exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  chime_scheduler #(
    .ALARM_TICKS (8'd6),
    .CHIME_EN    (1'b1)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .tick_en       (tick_en),
    .hour          (hour),
    .hour_changed  (hour_changed),
    .equal         (equal),
    .alarm_stop    (alarm_stop),
    .buzzer        (buzzer),
    .src           (src),
    .busy          (busy),
    .chime_pending (chime_pending)
  );

  initial begin
    tick_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick_en = 1'b1;
      @(negedge clk);
      tick_en = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (buzzer && !prev_buz) begin
      tot_p <= tot_p + 1;
      if (src == 2'b01) chime_p <= chime_p + 1;
    end
    prev_buz <= buzzer;
  end

  task automatic check(string tag, logic [31:0] obs,
                       logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic push(string tag, int v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(int obs);
    string t;
    int    e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_hc(logic [7:0] h);
    @(negedge clk);
    hour = h;
    hour_changed = 1'b1;
  endtask

  task automatic drop_hc();
    repeat (2) @(negedge clk);
    hour_changed = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || chime_pending) && k < 600) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(k < 600), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] hrs [9] = '{8'h15, 8'h00, 8'h12, 8'h13,
                          8'h23, 8'h01, 8'h1A, 8'h24, 8'h30};
  int         nps [9] = '{3, 12, 12, 1, 11, 1, 0, 0, 0};

  initial begin
    int bt;
    int bc;
    int k;
    rst = 1'b1;
    hour = 8'h00;
    hour_changed = 1'b0;
    equal = 1'b0;
    alarm_stop = 1'b0;
    repeat (3) sample();
    check("rst_buzzer", buzzer, 0);
    check("rst_src", src, 0);
    check("rst_busy", busy, 0);
    check("rst_pending", chime_pending, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // chime table: valid hours and invalid BCD
    for (int i = 0; i < 9; i++) begin
      bt = tot_p;
      push($sformatf("chime_pulses_%02h", hrs[i]), nps[i]);
      raise_hc(hrs[i]);
      sample();
      check("chime_start_buz", buzzer, 32'(nps[i] != 0));
      check("chime_start_src", src, (nps[i] != 0) ? 1 : 0);
      check("chime_start_busy", busy, 32'(nps[i] != 0));
      drop_hc();
      wait_idle();
      pop_check(tot_p - bt);
    end

    // alarm alone: 6 ticks, 3 ON phases
    bt = tot_p;
    push("alarm_pulses", 3);
    @(negedge clk);
    equal = 1'b1;
    sample();
    check("alarm_start_buz", buzzer, 1);
    check("alarm_start_src", src, 2);
    repeat (4) @(negedge clk);
    equal = 1'b0;
    wait_idle();
    pop_check(tot_p - bt);

    // alarm preempts a 9-beep chime after its 2nd pulse
    bt = tot_p;
    bc = chime_p;
    push("preempt_chime_pulses", 2);
    push("preempt_total_pulses", 5);
    raise_hc(8'h09);
    drop_hc();
    k = 0;
    while (!((chime_p - bc) == 2 && !buzzer) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("preempt_wait", 32'(k < 200), 1);
    equal = 1'b1;
    sample();
    check("preempt_src", src, 2);
    check("preempt_buz", buzzer, 1);
    repeat (3) @(negedge clk);
    equal = 1'b0;
    wait_idle();
    pop_check(chime_p - bc);
    pop_check(tot_p - bt);

    // chime deferred during alarm, released by stop
    bc = chime_p;
    push("deferred_chime_pulses", 2);
    @(negedge clk);
    equal = 1'b1;
    repeat (2) @(negedge clk);
    raise_hc(8'h02);
    sample();
    check("defer_pending", chime_pending, 1);
    check("defer_src", src, 2);
    drop_hc();
    equal = 1'b0;
    @(negedge clk);
    alarm_stop = 1'b1;
    sample();
    check("stop_buz", buzzer, 0);
    check("stop_src", src, 0);
    check("stop_pending", chime_pending, 1);
    @(negedge clk);
    alarm_stop = 1'b0;
    sample();
    check("deferred_start_buz", buzzer, 1);
    check("deferred_start_src", src, 1);
    check("deferred_pending_clr", chime_pending, 0);
    wait_idle();
    pop_check(chime_p - bc);

    // later chime request overwrites stored count
    bc = chime_p;
    push("overwrite_chime_pulses", 3);
    @(negedge clk);
    equal = 1'b1;
    repeat (2) @(negedge clk);
    raise_hc(8'h05);
    drop_hc();
    raise_hc(8'h15);
    drop_hc();
    equal = 1'b0;
    @(negedge clk);
    alarm_stop = 1'b1;
    @(negedge clk);
    alarm_stop = 1'b0;
    wait_idle();
    pop_check(chime_p - bc);

    // reset during ALARM_ON with a pending chime
    bc = chime_p;
    push("post_reset_chime_pulses", 0);
    @(negedge clk);
    equal = 1'b1;
    @(negedge clk);
    raise_hc(8'h04);
    sample();
    check("rst_case_pending", chime_pending, 1);
    k = 0;
    while (!buzzer && k < 50) begin
      sample();
      k++;
    end
    check("rst_case_alarm_on", buzzer, 1);
    @(negedge clk);
    rst = 1'b1;
    hour_changed = 1'b0;
    equal = 1'b0;
    sample();
    check("midrst_buzzer", buzzer, 0);
    check("midrst_src", src, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pending", chime_pending, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("midrst_busy_after", busy, 0);
    pop_check(chime_p - bc);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
